// File: rtl/l2_mem_sequencer.sv
// l2_mem_sequencer
//   Owns the single DRAM request port and sequences it between the boot
//   loader (image copy into DRAM) and the L2 miss/evict path. Boot traffic
//   must finish before the L2 port is served. A dirty miss (write and read
//   both requested) becomes a write-back followed by a fill. Every
//   completed DRAM read/write is counted in saturating counters.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   boot_valid/last/index/tag/data -> boot_ready (pulse), boot_done (sticky)
//   l2_read/l2_write/l2_index/l2_tag/l2_write_tag/l2_write_data
//                            -> l2_read_data, l2_ready (pulse)
//   mem_read/mem_write/mem_index/mem_tag/mem_write_tag/mem_write_data
//                            <- mem_read_data, mem_ready (pulse)
//   busy                     sequencer is not idle
//   rd_cnt, wr_cnt           completed DRAM reads / writes, saturating
//
// States
//   IDLE    | waiting for a request
//   BOOT_WR | boot line write outstanding
//   L2_WR   | L2 write-back outstanding (fill may follow)
//   L2_RD   | L2 fill outstanding
//   GAP     | one quiet cycle so a held request level is not re-issued

module l2_mem_sequencer #(
  parameter int IDX_W  = 8,
  parameter int TAG_W  = 18,
  parameter int LINE_W = 512,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_valid,
  input  logic              boot_last,
  input  logic [IDX_W-1:0]  boot_index,
  input  logic [TAG_W-1:0]  boot_tag,
  input  logic [LINE_W-1:0] boot_data,
  output logic              boot_ready,
  output logic              boot_done,
  input  logic              l2_read,
  input  logic              l2_write,
  input  logic [IDX_W-1:0]  l2_index,
  input  logic [TAG_W-1:0]  l2_tag,
  input  logic [TAG_W-1:0]  l2_write_tag,
  input  logic [LINE_W-1:0] l2_write_data,
  output logic [LINE_W-1:0] l2_read_data,
  output logic              l2_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [IDX_W-1:0]  mem_index,
  output logic [TAG_W-1:0]  mem_tag,
  output logic [TAG_W-1:0]  mem_write_tag,
  output logic [LINE_W-1:0] mem_write_data,
  input  logic [LINE_W-1:0] mem_read_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  typedef enum logic [2:0] {IDLE, BOOT_WR, L2_WR, L2_RD, GAP} state_t;

  state_t state, state_nxt;

  logic              last_q, last_nxt;
  logic              rd_pend, rd_pend_nxt;
  logic              boot_ready_nxt, boot_done_nxt, l2_ready_nxt;
  logic              mem_read_nxt, mem_write_nxt, busy_nxt;
  logic [IDX_W-1:0]  mem_index_nxt;
  logic [TAG_W-1:0]  mem_tag_nxt, mem_write_tag_nxt;
  logic [LINE_W-1:0] mem_write_data_nxt, l2_read_data_nxt;
  logic [CNT_W-1:0]  rd_cnt_nxt, wr_cnt_nxt, rd_cnt_inc, wr_cnt_inc;

  assign rd_cnt_inc = (rd_cnt == '1) ? rd_cnt : rd_cnt + CNT_W'(1);
  assign wr_cnt_inc = (wr_cnt == '1) ? wr_cnt : wr_cnt + CNT_W'(1);

  always_comb begin
    state_nxt          = state;
    last_nxt           = last_q;
    rd_pend_nxt        = rd_pend;
    boot_ready_nxt     = 1'b0;
    l2_ready_nxt       = 1'b0;
    boot_done_nxt      = boot_done;
    mem_read_nxt       = mem_read;
    mem_write_nxt      = mem_write;
    mem_index_nxt      = mem_index;
    mem_tag_nxt        = mem_tag;
    mem_write_tag_nxt  = mem_write_tag;
    mem_write_data_nxt = mem_write_data;
    l2_read_data_nxt   = l2_read_data;
    rd_cnt_nxt         = rd_cnt;
    wr_cnt_nxt         = wr_cnt;

    case (state)
      IDLE: begin
        if (!boot_done) begin
          if (boot_valid) begin
            mem_index_nxt      = boot_index;
            mem_write_tag_nxt  = boot_tag;
            mem_write_data_nxt = boot_data;
            last_nxt           = boot_last;
            mem_write_nxt      = 1'b1;
            state_nxt          = BOOT_WR;
          end
        end else if (l2_write) begin
          // Fill tag is captured now so the fill after the write-back does
          // not depend on the requester holding its inputs steady.
          mem_index_nxt      = l2_index;
          mem_write_tag_nxt  = l2_write_tag;
          mem_write_data_nxt = l2_write_data;
          mem_tag_nxt        = l2_tag;
          rd_pend_nxt        = l2_read;
          mem_write_nxt      = 1'b1;
          state_nxt          = L2_WR;
        end else if (l2_read) begin
          mem_index_nxt = l2_index;
          mem_tag_nxt   = l2_tag;
          rd_pend_nxt   = 1'b0;
          mem_read_nxt  = 1'b1;
          state_nxt     = L2_RD;
        end
      end
      BOOT_WR: begin
        if (mem_ready) begin
          mem_write_nxt  = 1'b0;
          boot_ready_nxt = 1'b1;
          boot_done_nxt  = boot_done | last_q;
          wr_cnt_nxt     = wr_cnt_inc;
          state_nxt      = GAP;
        end
      end
      L2_WR: begin
        if (mem_ready) begin
          mem_write_nxt = 1'b0;
          wr_cnt_nxt    = wr_cnt_inc;
          if (rd_pend) begin
            mem_read_nxt = 1'b1;
            state_nxt    = L2_RD;
          end else begin
            l2_ready_nxt = 1'b1;
            state_nxt    = GAP;
          end
        end
      end
      L2_RD: begin
        if (mem_ready) begin
          mem_read_nxt     = 1'b0;
          l2_read_data_nxt = mem_read_data;
          l2_ready_nxt     = 1'b1;
          rd_cnt_nxt       = rd_cnt_inc;
          rd_pend_nxt      = 1'b0;
          state_nxt        = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_q         <= 1'b0;
      rd_pend        <= 1'b0;
      boot_ready     <= 1'b0;
      boot_done      <= 1'b0;
      l2_ready       <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_index      <= '0;
      mem_tag        <= '0;
      mem_write_tag  <= '0;
      mem_write_data <= '0;
      l2_read_data   <= '0;
      busy           <= 1'b0;
      rd_cnt         <= '0;
      wr_cnt         <= '0;
    end else begin
      state          <= state_nxt;
      last_q         <= last_nxt;
      rd_pend        <= rd_pend_nxt;
      boot_ready     <= boot_ready_nxt;
      boot_done      <= boot_done_nxt;
      l2_ready       <= l2_ready_nxt;
      mem_read       <= mem_read_nxt;
      mem_write      <= mem_write_nxt;
      mem_index      <= mem_index_nxt;
      mem_tag        <= mem_tag_nxt;
      mem_write_tag  <= mem_write_tag_nxt;
      mem_write_data <= mem_write_data_nxt;
      l2_read_data   <= l2_read_data_nxt;
      busy           <= busy_nxt;
      rd_cnt         <= rd_cnt_nxt;
      wr_cnt         <= wr_cnt_nxt;
    end
  end

endmodule
